// File: rtl/cpu_loader_pkg.sv
// ---------------------------------------------------------------------------
// cpu_loader_pkg : shared constants and RX state encoding for the UART loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_loader_pkg;

  localparam int          DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [15:0] DEFAULT_END_WORD     = 16'hE000;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte : 8N1 UART receiver with 2-flop input synchronizer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import cpu_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          valid_n, ferr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects short glitches on an idle line
        if (cnt == HALF) begin
          cnt_n = '0;
          if (!rx_sync) begin
            state_n = RX_DATA;
            bit_n   = '0;
          end else begin
            state_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_sync) valid_n = 1'b1;
          else         ferr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

`default_nettype wire

// File: rtl/uart_instr_loader.sv
// ---------------------------------------------------------------------------
// uart_instr_loader : assembles UART byte pairs into instruction-memory writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_instr_loader
  import cpu_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [15:0] END_WORD     = DEFAULT_END_WORD
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_instr_transmit_done,
  output logic [7:0]  o_max_addr,
  output logic        o_frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [7:0]  wr_ptr;
  logic [15:0] word;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .rx         (i_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (o_frame_err)
  );

  assign word = {hi_byte, rx_byte};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase                 <= 1'b0;
      hi_byte               <= '0;
      wr_ptr                <= '0;
      o_wr_en               <= 1'b0;
      o_wr_addr             <= '0;
      o_wr_data             <= '0;
      o_max_addr            <= '0;
      o_instr_transmit_done <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      // After completion the receiver keeps running but the loader is frozen
      if (!o_instr_transmit_done) begin
        if (o_frame_err) begin
          phase <= 1'b0;
        end else if (byte_valid) begin
          if (!phase) begin
            hi_byte <= rx_byte;
            phase   <= 1'b1;
          end else begin
            phase      <= 1'b0;
            o_wr_en    <= 1'b1;
            o_wr_addr  <= wr_ptr;
            o_wr_data  <= word;
            o_max_addr <= wr_ptr;
            if (word == END_WORD || wr_ptr == 8'hFF)
              o_instr_transmit_done <= 1'b1;
            if (wr_ptr != 8'hFF)
              wr_ptr <= wr_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_instr_loader : directed scoreboard bench for uart_instr_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_instr_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        done;
  logic [7:0]  max_addr;
  logic        frame_err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  ferr_seen   = 0;
  int  writes_seen = 0;

  uart_instr_loader #(
    .CLKS_PER_BIT (CPB),
    .END_WORD     (16'hE000)
  ) u_dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_rx                  (rx),
    .o_wr_en               (wr_en),
    .o_wr_addr             (wr_addr),
    .o_wr_data             (wr_data),
    .o_instr_transmit_done (done),
    .o_max_addr            (max_addr),
    .o_frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [15:0] d, input logic dn);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.done = dn;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (wr_en) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'h00, wr_addr, wr_data}, 32'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("done_at_write", 32'(done), 32'(e.done));
        check("max_addr_at_write", 32'(max_addr), 32'(e.addr));
      end
    end
  end

  task automatic hold_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold_bits(1);
    end
    rx = stop_bit;
    hold_bits(1);
    rx = 1'b1;
    hold_bits(2);
  endtask

  task automatic do_reset();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_max_addr", 32'(max_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ferr_seen   = 0;
    writes_seen = 0;
  endtask

  initial begin
    // Single word
    do_reset();
    expect_wr(8'h00, 16'h4100, 1'b0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t1_writes", 32'(writes_seen), 32'd1);
    check("t1_max_addr", 32'(max_addr), 32'd0);
    check("t1_done", 32'(done), 32'd0);

    // Halt word terminates loading; later bytes are ignored
    do_reset();
    expect_wr(8'h00, 16'h4100, 1'b0);
    expect_wr(8'h01, 16'h8180, 1'b0);
    expect_wr(8'h02, 16'hE000, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t2_writes", 32'(writes_seen), 32'd3);
    check("t2_max_addr", 32'(max_addr), 32'd2);
    check("t2_done", 32'(done), 32'd1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t2_post_done_writes", 32'(writes_seen), 32'd3);
    check("t2_post_done_max", 32'(max_addr), 32'd2);

    // Short low glitch on an idle line (about a third of a bit)
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    hold_bits(12);
    check("t3_writes", 32'(writes_seen), 32'd0);
    check("t3_frame_err", 32'(ferr_seen), 32'd0);
    check("t3_phase_clean", 32'(u_dut.phase), 32'd0);

    // Frame error drops the partial word
    do_reset();
    expect_wr(8'h00, 16'h8180, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h81, 1'b1);
    send_byte(8'h80, 1'b1);
    check("t4_frame_err", 32'(ferr_seen), 32'd1);
    check("t4_writes", 32'(writes_seen), 32'd1);

    // Reset in the middle of bit 4 of the second byte
    do_reset();
    send_byte(8'h41, 1'b1);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      hold_bits(1);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    hold_bits(2);
    writes_seen = 0;
    expect_wr(8'h00, 16'h4100, 1'b0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t5_writes", 32'(writes_seen), 32'd1);

    // Fill all 256 locations; address 0xFF completes loading
    do_reset();
    for (int i = 0; i < 256; i++) begin
      expect_wr(8'(i), 16'h1234, (i == 255));
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
    end
    check("t6_writes", 32'(writes_seen), 32'd256);
    check("t6_done", 32'(done), 32'd1);
    check("t6_max_addr", 32'(max_addr), 32'hFF);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("t6_post_done_writes", 32'(writes_seen), 32'd256);
    check("t6_post_done_addr", 32'(wr_addr), 32'hFF);
    check("pending_at_end", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
